// File: rtl/sgd_mem_rd_req_pkg.sv
// Shared definitions for the SGD external-memory read path: R-channel tags,
// AXI beat size and the read-request FSM state encoding.
package sgd_mem_rd_req_pkg;

    // One AXI beat on the 512-bit memory port.
    localparam int unsigned AXI_BEAT_BYTES = 64;

    // ARID tags used by the read-response dispatcher to split the R channel.
    localparam logic [3:0] MEM_RD_A_TAG = 4'd1;
    localparam logic [3:0] MEM_RD_B_TAG = 4'd2;

    // Read-request generator states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ_B,
        ST_REQ_A,
        ST_NEXT,
        ST_DONE
    } mem_rd_state_t;

endpackage

// File: rtl/sgd_beat_credit.sv
// Up/down counter of outstanding R beats plus the "may another request of
// N beats be issued" compare against the dispatcher's buffering limit.
module sgd_beat_credit
    import sgd_mem_rd_req_pkg::*;
#(
    parameter int unsigned MAX_OUT_BEATS = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       add_en_i,     // AR handshake this cycle
    input  logic [7:0] add_len_i,    // ARLEN of that handshake
    input  logic       beat_done_i,  // one R beat accepted this cycle
    input  logic [8:0] req_beats_i,  // beats of the request about to be raised
    output logic       can_issue_o
);

    logic [15:0] out_beats_q;
    logic [15:0] out_beats_d;
    logic [16:0] inc;
    logic [16:0] dec;

    // Next credit value: add ARLEN+1 on a handshake, drop one per beat, never below zero.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        inc         = '0;
        dec         = '0;
        out_beats_d = out_beats_q;
        if (add_en_i) begin
            inc = 17'(add_len_i) + 17'd1;
        end
        // A beat arriving with nothing outstanding is stale (e.g. from before a reset).
        if (beat_done_i && (out_beats_q != '0)) begin
            dec = 17'd1;
        end
        out_beats_d = 16'(17'(out_beats_q) + inc - dec);
    end

    // Issue is allowed while the new request still fits within the limit.
    always_comb begin
        can_issue_o = ({16'd0, out_beats_q} + 32'(req_beats_i)) <= 32'(MAX_OUT_BEATS);
    end

    // Credit register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_beats_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all flops update together at the edge.
            out_beats_q <= out_beats_d;
        end
    end

endmodule

// File: rtl/sgd_mem_rd_req.sv
// Read-request generator for the SGD engine. Walks the label vector b and
// the sample matrix a for a number of epochs, issuing one b beat followed by
// a_bursts_per_b a bursts, tagged so the dispatcher can separate R data.
module sgd_mem_rd_req
    import sgd_mem_rd_req_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = 64,
    parameter int unsigned ID_WIDTH      = 5,
    parameter int unsigned BURST_LEN     = 16,
    parameter int unsigned MAX_OUT_BEATS = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  started,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [31:0]           num_b_beats,
    input  logic [15:0]           a_bursts_per_b,
    input  logic [31:0]           num_epochs,
    output logic                  m_axi_ARVALID,
    input  logic                  m_axi_ARREADY,
    output logic [ADDR_WIDTH-1:0] m_axi_ARADDR,
    output logic [7:0]            m_axi_ARLEN,
    output logic [ID_WIDTH-1:0]   m_axi_ARID,
    output logic [2:0]            m_axi_ARSIZE,
    output logic [1:0]            m_axi_ARBURST,
    input  logic                  rd_beat_done,
    output logic                  done,
    output logic [31:0]           state_counters_mem_rd
);

    localparam logic [7:0]            A_LEN  = 8'(BURST_LEN - 1);
    localparam logic [ADDR_WIDTH-1:0] B_STEP = ADDR_WIDTH'(AXI_BEAT_BYTES);
    localparam logic [ADDR_WIDTH-1:0] A_STEP = ADDR_WIDTH'(BURST_LEN * AXI_BEAT_BYTES);
    localparam logic [ID_WIDTH-1:0]   ID_A   = ID_WIDTH'(MEM_RD_A_TAG);
    localparam logic [ID_WIDTH-1:0]   ID_B   = ID_WIDTH'(MEM_RD_B_TAG);

    mem_rd_state_t         state_q;
    logic                  arvalid_q;
    logic [ADDR_WIDTH-1:0] araddr_q;
    logic [7:0]            arlen_q;
    logic [ID_WIDTH-1:0]   arid_q;
    logic                  done_q;
    logic [31:0]           stall_q;

    // Job configuration captured at start.
    logic [ADDR_WIDTH-1:0] a_base_q;
    logic [ADDR_WIDTH-1:0] b_base_q;
    logic [31:0]           num_b_q;
    logic [15:0]           a_per_b_q;
    logic [31:0]           num_ep_q;

    // Walk position.
    logic [ADDR_WIDTH-1:0] a_ptr_q;
    logic [ADDR_WIDTH-1:0] b_ptr_q;
    logic [15:0]           a_cnt_q;
    logic [31:0]           b_cnt_q;
    logic [31:0]           epoch_q;

    logic       ar_hs;
    logic       in_req;
    logic       can_issue;
    logic       stall;
    logic [8:0] req_beats;

    // Handshake, beats of the pending request and credit-stall detection.
    always_comb begin
        ar_hs     = arvalid_q & m_axi_ARREADY;
        in_req    = (state_q == ST_REQ_B) || (state_q == ST_REQ_A);
        req_beats = (state_q == ST_REQ_A) ? 9'(BURST_LEN) : 9'd1;
        stall     = in_req & ~arvalid_q & ~can_issue;
    end

    sgd_beat_credit #(
        .MAX_OUT_BEATS(MAX_OUT_BEATS)
    ) u_credit (
        .clk        (clk),
        .rst_n      (rst_n),
        .add_en_i   (ar_hs),
        .add_len_i  (arlen_q),
        .beat_done_i(rd_beat_done),
        .req_beats_i(req_beats),
        .can_issue_o(can_issue)
    );

    // Request FSM with registered AR channel, done flag and stall counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arid_q    <= '0;
            done_q    <= 1'b0;
            stall_q   <= '0;
            a_base_q  <= '0;
            b_base_q  <= '0;
            num_b_q   <= '0;
            a_per_b_q <= '0;
            num_ep_q  <= '0;
            a_ptr_q   <= '0;
            b_ptr_q   <= '0;
            a_cnt_q   <= '0;
            b_cnt_q   <= '0;
            epoch_q   <= '0;
        end else begin
            if (stall && (stall_q != '1)) begin
                stall_q <= stall_q + 32'd1;
            end

            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (started) begin
                        a_base_q  <= addr_a;
                        b_base_q  <= addr_b;
                        num_b_q   <= num_b_beats;
                        a_per_b_q <= a_bursts_per_b;
                        num_ep_q  <= num_epochs;
                        a_ptr_q   <= addr_a;
                        b_ptr_q   <= addr_b;
                        a_cnt_q   <= '0;
                        b_cnt_q   <= '0;
                        epoch_q   <= '0;
                        stall_q   <= '0;
                        if ((num_b_beats == '0) || (num_epochs == '0)) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            done_q  <= 1'b0;
                            state_q <= ST_REQ_B;
                        end
                    end
                end

                ST_REQ_B: begin
                    if (!arvalid_q) begin
                        if (can_issue) begin
                            arvalid_q <= 1'b1;
                            araddr_q  <= b_ptr_q;
                            arlen_q   <= 8'd0;
                            arid_q    <= ID_B;
                        end
                    end else if (m_axi_ARREADY) begin
                        arvalid_q <= 1'b0;
                        b_ptr_q   <= b_ptr_q + B_STEP;
                        state_q   <= (a_per_b_q == '0) ? ST_NEXT : ST_REQ_A;
                    end
                end

                ST_REQ_A: begin
                    if (!arvalid_q) begin
                        if (can_issue) begin
                            arvalid_q <= 1'b1;
                            araddr_q  <= a_ptr_q;
                            arlen_q   <= A_LEN;
                            arid_q    <= ID_A;
                        end
                    end else if (m_axi_ARREADY) begin
                        arvalid_q <= 1'b0;
                        a_ptr_q   <= a_ptr_q + A_STEP;
                        a_cnt_q   <= a_cnt_q + 16'd1;
                        if ((a_cnt_q + 16'd1) == a_per_b_q) begin
                            state_q <= ST_NEXT;
                        end
                    end
                end

                ST_NEXT: begin
                    a_cnt_q <= '0;
                    if ((b_cnt_q + 32'd1) < num_b_q) begin
                        b_cnt_q <= b_cnt_q + 32'd1;
                        state_q <= ST_REQ_B;
                    end else if ((epoch_q + 32'd1) == num_ep_q) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        epoch_q <= epoch_q + 32'd1;
                        b_cnt_q <= '0;
                        a_ptr_q <= a_base_q;
                        b_ptr_q <= b_base_q;
                        state_q <= ST_REQ_B;
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign m_axi_ARVALID         = arvalid_q;
    assign m_axi_ARADDR          = araddr_q;
    assign m_axi_ARLEN           = arlen_q;
    assign m_axi_ARID            = arid_q;
    assign m_axi_ARSIZE          = 3'b110;
    assign m_axi_ARBURST         = 2'b01;
    assign done                  = done_q;
    assign state_counters_mem_rd = stall_q;

endmodule
